// File: rtl/nv_nvdla_pdp_med1d_pkg.sv
// Shared definitions for the PDP int8 streaming 1D median filter.
//   - default sample width and legal parameter ranges
//   - med_half(): half window width of an odd kernel
//   - med_state_e: line FSM states
//   - med_lane_lsb(): bit offset of a lane inside a packed beat
package nv_nvdla_pdp_med1d_pkg;

    localparam int MED_DATA_W     = 8;
    localparam int MED_KERNEL_MIN = 3;
    localparam int MED_KERNEL_MAX = 7;
    localparam int MED_LANES_MAX  = 8;
    // Line-position and flush counters; HALF is at most 3, ranks at most 6.
    localparam int MED_CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } med_state_e;

    function automatic int med_half(input int kernel);
        return (kernel - 1) / 2;
    endfunction

    function automatic bit med_kernel_ok(input int kernel);
        return (kernel >= MED_KERNEL_MIN) && (kernel <= MED_KERNEL_MAX) && (kernel % 2 == 1);
    endfunction

    function automatic int med_lane_lsb(input int lane, input int data_w);
        return lane * data_w;
    endfunction

endpackage

// File: rtl/nv_nvdla_pdp_med1d_rank_sel.sv
// Combinational median of one KERNEL-wide window by rank counting.
// Ports:
//   win  in   KERNEL signed samples, win[KERNEL-1] newest
//   med  out  sample whose rank equals HALF
// Ties are broken by position (lower index ranks lower), so every element
// gets a distinct rank and exactly one element matches HALF.
module nv_nvdla_pdp_med1d_rank_sel
    import nv_nvdla_pdp_med1d_pkg::*;
#(
    parameter int DATA_W = MED_DATA_W,
    parameter int KERNEL = 3
) (
    input  logic [KERNEL-1:0][DATA_W-1:0] win,
    output logic [DATA_W-1:0]             med
);

    localparam logic [MED_CNT_W-1:0] HALF_C = MED_CNT_W'(med_half(KERNEL));

    logic [MED_CNT_W-1:0] rank [KERNEL];

    always_comb begin
        for (int j = 0; j < KERNEL; j++) begin
            rank[j] = '0;
            for (int k = 0; k < KERNEL; k++) begin
                if (k != j) begin
                    if (($signed(win[k]) < $signed(win[j])) || ((win[k] == win[j]) && (k < j)))
                        rank[j] = rank[j] + MED_CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        med = '0;
        for (int j = 0; j < KERNEL; j++) begin
            if (rank[j] == HALF_C)
                med = win[j];
        end
    end

endmodule

// File: rtl/nv_nvdla_pdp_core_med1d_stream.sv
// Streaming 1D median filter, LANES int8 channels in lockstep.
// Ports:
//   nvdla_core_clk / nvdla_core_rst  clock, synchronous active-high reset
//   med_en                           1=median, 0=bypass; latched on sol beat
//   in_pvld/in_prdy/in_pd            input beat handshake and packed samples
//   in_sol/in_eol                    line start / line end flags
//   out_pvld/out_prdy/out_pd         output beat handshake and packed medians
//   out_eol                          last output of a line
// One output per input sample. The window is centred on a sample HALF
// positions behind the newest one, so the first HALF accepts of a line emit
// nothing and the line end is drained with HALF flush cycles that replicate
// the last sample. The left edge is handled by filling the window on sol.
module nv_nvdla_pdp_core_med1d_stream
    import nv_nvdla_pdp_med1d_pkg::*;
#(
    parameter int DATA_W = MED_DATA_W,
    parameter int KERNEL = 3,
    parameter int LANES  = 1
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    input  logic                    med_en,
    input  logic                    in_pvld,
    output logic                    in_prdy,
    input  logic [LANES*DATA_W-1:0] in_pd,
    input  logic                    in_sol,
    input  logic                    in_eol,
    output logic                    out_pvld,
    input  logic                    out_prdy,
    output logic [LANES*DATA_W-1:0] out_pd,
    output logic                    out_eol
);

    localparam int HALF = med_half(KERNEL);
    localparam logic [MED_CNT_W-1:0] HALF_C = MED_CNT_W'(HALF);

    if (!med_kernel_ok(KERNEL) || (LANES < 1) || (LANES > MED_LANES_MAX)) begin : g_bad_param
        $error("nv_nvdla_pdp_core_med1d_stream: KERNEL must be odd 3..7 and LANES 1..8");
    end

    med_state_e                              state_q, state_d;
    logic [MED_CNT_W-1:0]                    idx_q, idx_d;
    logic [MED_CNT_W-1:0]                    fcnt_q, fcnt_d;
    logic                                    en_q, en_d;
    logic [LANES-1:0][KERNEL-1:0][DATA_W-1:0] win_q, win_d;
    logic                                    out_pvld_q, out_pvld_d;
    logic                                    out_eol_q, out_eol_d;
    logic [LANES*DATA_W-1:0]                 out_pd_q, out_pd_d;

    logic [LANES-1:0][DATA_W-1:0] in_lane;
    logic [LANES-1:0][DATA_W-1:0] med_lane;
    logic load_ok, acc, is_sol;
    logic emit, emit_eol, byp;

    // Position counter only needs to know whether the centre has reached the
    // line, so it stops at HALF.
    function automatic logic [MED_CNT_W-1:0] sat_inc(input logic [MED_CNT_W-1:0] v);
        return (v >= HALF_C) ? HALF_C : v + MED_CNT_W'(1);
    endfunction

    assign load_ok = !out_pvld_q || out_prdy;
    assign in_prdy = (state_q != FLUSH) && load_ok;
    assign acc     = in_pvld && in_prdy;
    // Every accept from IDLE starts a line, flagged or not.
    assign is_sol  = acc && (in_sol || (state_q == IDLE));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fcnt_d   = fcnt_q;
        en_d     = en_q;
        win_d    = win_q;
        emit     = 1'b0;
        emit_eol = 1'b0;
        byp      = 1'b0;
        if (acc) begin
            if (is_sol) begin
                en_d  = med_en;
                idx_d = '0;
                for (int n = 0; n < LANES; n++)
                    for (int k = 0; k < KERNEL; k++)
                        win_d[n][k] = in_lane[n];
            end else begin
                idx_d = sat_inc(idx_q);
                for (int n = 0; n < LANES; n++) begin
                    for (int k = 0; k < KERNEL - 1; k++)
                        win_d[n][k] = win_q[n][k+1];
                    win_d[n][KERNEL-1] = in_lane[n];
                end
            end
            // en_d already holds the mode for this line, including a fresh sol.
            if (en_d) begin
                emit = (idx_d >= HALF_C);
                if (in_eol) begin
                    if (HALF > 0) begin
                        state_d = FLUSH;
                        fcnt_d  = '0;
                    end else begin
                        state_d  = IDLE;
                        emit_eol = 1'b1;
                    end
                end else begin
                    state_d = RUN;
                end
            end else begin
                byp      = 1'b1;
                emit     = 1'b1;
                emit_eol = in_eol;
                state_d  = in_eol ? IDLE : RUN;
            end
        end else if ((state_q == FLUSH) && load_ok) begin
            idx_d  = sat_inc(idx_q);
            fcnt_d = fcnt_q + MED_CNT_W'(1);
            for (int n = 0; n < LANES; n++) begin
                for (int k = 0; k < KERNEL - 1; k++)
                    win_d[n][k] = win_q[n][k+1];
                win_d[n][KERNEL-1] = win_q[n][KERNEL-1];
            end
            emit = (idx_d >= HALF_C);
            // The final flush step always centres on the last sample.
            if (fcnt_d == HALF_C) begin
                state_d  = IDLE;
                emit_eol = 1'b1;
            end
        end
    end

    // Median is taken on the window as it will be after this cycle's update,
    // giving one cycle from accept to out_pvld.
    for (genvar n = 0; n < LANES; n++) begin : g_lane
        assign in_lane[n] = in_pd[med_lane_lsb(n, DATA_W) +: DATA_W];
        nv_nvdla_pdp_med1d_rank_sel #(
            .DATA_W (DATA_W),
            .KERNEL (KERNEL)
        ) u_rank_sel (
            .win (win_d[n]),
            .med (med_lane[n])
        );
    end

    always_comb begin
        out_pvld_d = out_pvld_q;
        out_pd_d   = out_pd_q;
        out_eol_d  = out_eol_q;
        if (load_ok) begin
            out_pvld_d = emit;
            if (emit) begin
                out_pd_d  = byp ? in_pd : med_lane;
                out_eol_d = emit_eol;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            fcnt_q     <= '0;
            en_q       <= 1'b0;
            win_q      <= '0;
            out_pvld_q <= 1'b0;
            out_pd_q   <= '0;
            out_eol_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            fcnt_q     <= fcnt_d;
            en_q       <= en_d;
            win_q      <= win_d;
            out_pvld_q <= out_pvld_d;
            out_pd_q   <= out_pd_d;
            out_eol_q  <= out_eol_d;
        end
    end

    assign out_pvld = out_pvld_q;
    assign out_pd   = out_pd_q;
    assign out_eol  = out_eol_q;

endmodule

// File: tb/tb_nv_nvdla_pdp_core_med1d_stream.sv
// Bench for the streaming median filter (KERNEL=5, LANES=2).
// Reference: each output i of a line s[0..N-1] is the sorted-middle of
// s[clamp(i-HALF..i+HALF, 0, N-1)]; bypass lines pass samples through.
module tb_nv_nvdla_pdp_core_med1d_stream;

    localparam int DW   = 8;
    localparam int K    = 5;
    localparam int L    = 2;
    localparam int H    = (K - 1) / 2;
    localparam int PW   = L * DW;
    localparam int MAXN = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          med_en = 1'b0, in_pvld = 1'b0, in_sol = 1'b0, in_eol = 1'b0;
    logic          out_prdy = 1'b1;
    logic [PW-1:0] in_pd = '0;
    logic          in_prdy, out_pvld, out_eol;
    logic [PW-1:0] out_pd;

    int          checks = 0;
    int          errors = 0;
    bit          rnd_rdy = 1'b0;
    logic [PW:0] exp_q[$];
    logic [PW:0] obs_q[$];
    int          ln[L][MAXN];

    always #5 clk = ~clk;

    nv_nvdla_pdp_core_med1d_stream #(
        .DATA_W (DW),
        .KERNEL (K),
        .LANES  (L)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .med_en         (med_en),
        .in_pvld        (in_pvld),
        .in_prdy        (in_prdy),
        .in_pd          (in_pd),
        .in_sol         (in_sol),
        .in_eol         (in_eol),
        .out_pvld       (out_pvld),
        .out_prdy       (out_prdy),
        .out_pd         (out_pd),
        .out_eol        (out_eol)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: records accepted beats and checks stall stability.
    initial begin
        bit          stall_p;
        logic [PW:0] hold_p;
        stall_p = 1'b0;
        hold_p  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_p = 1'b0;
            end else begin
                if (stall_p)
                    chk("hold", 64'({out_pvld, out_pd, out_eol}), 64'({1'b1, hold_p}));
                if (out_pvld && out_prdy)
                    obs_q.push_back({out_pd, out_eol});
                stall_p = out_pvld && !out_prdy;
                hold_p  = {out_pd, out_eol};
            end
        end
    end

    // Random downstream back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_rdy) out_prdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [PW-1:0] pd, input bit sol, input bit eol, input bit en);
        int t;
        t = 0;
        in_pvld = 1'b1; in_pd = pd; in_sol = sol; in_eol = eol; med_en = en;
        forever begin
            @(negedge clk);
            if (in_prdy) break;
            t++;
            if (t > 200) begin
                chk("in_timeout", 64'(in_prdy), 64'(1));
                break;
            end
        end
        sync();
        in_pvld = 1'b0;
        in_pd   = PW'($urandom);
        in_sol  = 1'($urandom);
        in_eol  = 1'($urandom);
        med_en  = 1'($urandom);
    endtask

    function automatic logic [PW-1:0] pack_smp(input int i);
        logic [PW-1:0] pd;
        for (int l = 0; l < L; l++) pd[l*DW +: DW] = DW'(ln[l][i]);
        return pd;
    endfunction

    task automatic send_smp(input int i, input bit sol, input bit eol, input bit en);
        send_beat(pack_smp(i), sol, eol, en);
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Expected beats of a line of n samples; an aborted line (restarted by
    // sol, never closed by eol) only delivers the outputs whose window had
    // already been fully seen.
    task automatic model_line(input int n, input bit en, input bit abort);
        int nout;
        nout = (en && abort) ? n - H : n;
        for (int i = 0; i < nout; i++) begin
            logic [PW:0] e;
            e = '0;
            for (int l = 0; l < L; l++) begin
                int v;
                int w[K];
                int tmp;
                if (!en) begin
                    v = ln[l][i];
                end else begin
                    for (int d = 0; d < K; d++) w[d] = ln[l][clampi(i - H + d, 0, n - 1)];
                    for (int a = 0; a < K; a++)
                        for (int b = 0; b < K - 1 - a; b++)
                            if (w[b] > w[b+1]) begin tmp = w[b]; w[b] = w[b+1]; w[b+1] = tmp; end
                    v = w[H];
                end
                e[1 + l*DW +: DW] = DW'(v);
            end
            e[0] = !abort && (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    function automatic int rnd_smp();
        int tbl[5];
        tbl = '{-128, -1, 0, 1, 127};
        if ($urandom_range(0, 2) == 0) return tbl[$urandom_range(0, 4)];
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic run_line(input int n, input bit en, input bit abort, input bit imp_sol);
        for (int i = 0; i < n; i++) begin
            send_smp(i, (i == 0) && !imp_sol, (i == n - 1) && !abort, (i == 0) ? en : 1'($urandom));
            if ($urandom_range(0, 3) == 0) sync();
        end
        model_line(n, en, abort);
    endtask

    initial begin
        bit            prev_abort;
        int            cnt;
        logic [PW-1:0] epd;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pvld", 64'(out_pvld), 64'(0));
        chk("rst_pd",   64'(out_pd),   64'(0));
        chk("rst_eol",  64'(out_eol),  64'(0));
        chk("rst_prdy", 64'(in_prdy),  64'(1));
        sync();
        rst = 1'b0;

        // Ties plus a 4-cycle downstream stall before the last sample.
        ln[0][0:4] = '{1, 1, 1, 9, 9};
        ln[1][0:4] = '{-128, 127, 0, -1, 5};
        for (int i = 0; i < 4; i++) send_smp(i, i == 0, 1'b0, (i == 0) ? 1'b1 : 1'($urandom));
        out_prdy = 1'b0;
        in_pvld = 1'b1; in_pd = pack_smp(4); in_sol = 1'b0; in_eol = 1'b1; med_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_prdy", 64'(in_prdy),  64'(0));
            chk("bp_pvld", 64'(out_pvld), 64'(1));
            sync();
        end
        out_prdy = 1'b1;
        send_smp(4, 1'b0, 1'b1, 1'b0);
        model_line(5, 1'b1, 1'b0);

        // Single-sample line: HALF flush cycles with in_prdy low.
        ln[0][0] = -128; ln[1][0] = 55;
        send_smp(0, 1'b1, 1'b1, 1'b1);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_prdy) break;
            cnt++;
        end
        chk("flush_cyc", 64'(cnt), 64'(H));
        model_line(1, 1'b1, 1'b0);
        sync();

        // Bypass line, med_en toggled mid-line, latency 1, no flush.
        ln[0][0:2] = '{3, -4, 100};
        ln[1][0:2] = '{-7, 0, 8};
        for (int i = 0; i < 3; i++) begin
            send_smp(i, i == 0, i == 2, (i == 0) ? 1'b0 : 1'b1);
            epd = pack_smp(i);
            @(negedge clk);
            chk("byp_pvld", 64'(out_pvld), 64'(1));
            chk("byp_pd",   64'(out_pd),   64'(epd));
            if (i == 2) chk("byp_noflush", 64'(in_prdy), 64'(1));
            sync();
        end
        model_line(3, 1'b0, 1'b0);

        // Reset during the flush of a two-sample line drops it entirely.
        ln[0][0:1] = '{4, 8};
        ln[1][0:1] = '{-4, -8};
        send_smp(0, 1'b1, 1'b0, 1'b1);
        send_smp(1, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("rstf_pvld", 64'(out_pvld), 64'(0));
        chk("rstf_pd",   64'(out_pd),   64'(0));
        chk("rstf_prdy", 64'(in_prdy),  64'(1));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rstf_idle", 64'(out_pvld), 64'(0));
        end
        sync();
        ln[0][0] = 7; ln[1][0] = -9;
        send_smp(0, 1'b1, 1'b1, 1'b1);
        model_line(1, 1'b1, 1'b0);

        // Random lines, random modes, gaps, back-pressure, aborts, implicit sol.
        rnd_rdy = 1'b1;
        prev_abort = 1'b0;
        for (int r = 0; r < 120; r++) begin
            int n;
            bit en, abort, imp;
            n = $urandom_range(1, 10);
            for (int l = 0; l < L; l++)
                for (int i = 0; i < n; i++) ln[l][i] = rnd_smp();
            en    = ($urandom_range(0, 3) != 0);
            abort = ($urandom_range(0, 7) == 0) && (r != 119);
            imp   = !prev_abort && ($urandom_range(0, 2) == 0);
            run_line(n, en, abort, imp);
            prev_abort = abort;
        end

        sync();
        rnd_rdy = 1'b0;
        out_prdy = 1'b1;
        for (int t = 0; t < 2000 && obs_q.size() < exp_q.size(); t++) @(posedge clk);
        repeat (10) @(posedge clk);
        chk("n_out", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("beat%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
